// File: rtl/alu_serial_sequencer_if.sv
// Bit-slice bus between the serial sequencer (master) and one combinational 1-bit ALU slice (slave).
interface alu_serial_sequencer_if;
    logic       slice_op1;
    logic       slice_op2;
    logic       slice_cin;
    logic [2:0] slice_opsel;
    logic       slice_mode;
    logic       slice_result;
    logic       slice_cout;

    modport master (
        output slice_op1, slice_op2, slice_cin, slice_opsel, slice_mode,
        input  slice_result, slice_cout
    );

    modport slave (
        input  slice_op1, slice_op2, slice_cin, slice_opsel, slice_mode,
        output slice_result, slice_cout
    );
endinterface

// File: rtl/alu_serial_sequencer.sv
// Drives a 1-bit ALU slice LSB-first over WIDTH cycles, chaining carry and
// reassembling the serial result bits into a parallel word plus final carry.
module alu_serial_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     op1_in,
    input  logic [WIDTH-1:0]     op2_in,
    input  logic                 cin_in,
    input  logic [2:0]           opsel_in,
    input  logic                 mode_in,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     result_out,
    output logic                 cout_out,
    alu_serial_sequencer_if.master slice
);
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t            state_reg, state_next;
    logic [WIDTH-1:0]  a_reg, a_next;
    logic [WIDTH-1:0]  b_reg, b_next;
    logic [WIDTH-1:0]  res_reg, res_next;
    logic              carry_reg, carry_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [2:0]        opsel_reg, opsel_next;
    logic              mode_reg, mode_next;
    logic [WIDTH-1:0]  result_reg, result_next;
    logic              cout_reg, cout_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            res_reg    <= '0;
            carry_reg  <= 1'b0;
            cnt_reg    <= '0;
            opsel_reg  <= 3'b000;
            mode_reg   <= 1'b0;
            result_reg <= '0;
            cout_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            res_reg    <= res_next;
            carry_reg  <= carry_next;
            cnt_reg    <= cnt_next;
            opsel_reg  <= opsel_next;
            mode_reg   <= mode_next;
            result_reg <= result_next;
            cout_reg   <= cout_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        res_next    = res_reg;
        carry_next  = carry_reg;
        cnt_next    = cnt_reg;
        opsel_next  = opsel_reg;
        mode_next   = mode_reg;
        result_next = result_reg;
        cout_next   = cout_reg;
        busy        = 1'b0;
        done        = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    a_next     = op1_in;
                    b_next     = op2_in;
                    carry_next = cin_in;
                    opsel_next = opsel_in;
                    mode_next  = mode_in;
                    res_next   = '0;
                    cnt_next   = '0;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                busy       = 1'b1;
                a_next     = a_reg >> 1;
                b_next     = b_reg >> 1;
                res_next   = {slice.slice_result, res_reg[WIDTH-1:1]};
                carry_next = slice.slice_cout;
                cnt_next   = cnt_reg + CNT_W'(1);
                if (cnt_reg == CNT_W'(WIDTH - 1)) begin
                    // Final bit: publish the assembled word as DONE is entered.
                    result_next = res_next;
                    cout_next   = slice.slice_cout;
                    cnt_next    = '0;
                    state_next  = ST_DONE;
                end
            end
            ST_DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Operand bits and carry reach the slice only while a bit is being processed.
    assign slice.slice_op1   = (state_reg == ST_RUN) ? a_reg[0]  : 1'b0;
    assign slice.slice_op2   = (state_reg == ST_RUN) ? b_reg[0]  : 1'b0;
    assign slice.slice_cin   = (state_reg == ST_RUN) ? carry_reg : 1'b0;
    assign slice.slice_opsel = opsel_reg;
    assign slice.slice_mode  = mode_reg;

    assign result_out = result_reg;
    assign cout_out   = cout_reg;
endmodule

// File: tb/tb_alu_serial_sequencer.sv
// Directed bench for alu_serial_sequencer with a behavioural 1-bit slice model.
module tb_alu_serial_sequencer;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] op1_in = '0;
    logic [WIDTH-1:0] op2_in = '0;
    logic             cin_in = 1'b0;
    logic [2:0]       opsel_in = 3'b000;
    logic             mode_in = 1'b0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result_out;
    logic             cout_out;

    int n_cmp = 0;
    int n_bad = 0;

    alu_serial_sequencer_if sif();

    alu_serial_sequencer #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .op1_in     (op1_in),
        .op2_in     (op2_in),
        .cin_in     (cin_in),
        .opsel_in   (opsel_in),
        .mode_in    (mode_in),
        .busy       (busy),
        .done       (done),
        .result_out (result_out),
        .cout_out   (cout_out),
        .slice      (sif)
    );

    always #5 clk = ~clk;

    // Slice model: mode0/opsel000 full adder, mode0/opsel010 move, else xor.
    always_comb begin
        sif.slice_result = sif.slice_op1 ^ sif.slice_op2;
        sif.slice_cout   = 1'b0;
        if (sif.slice_mode == 1'b0 && sif.slice_opsel == 3'b000) begin
            sif.slice_result = sif.slice_op1 ^ sif.slice_op2 ^ sif.slice_cin;
            sif.slice_cout   = (sif.slice_op1 & sif.slice_op2) |
                               (sif.slice_cin & (sif.slice_op1 ^ sif.slice_op2));
        end else if (sif.slice_mode == 1'b0 && sif.slice_opsel == 3'b010) begin
            sif.slice_result = sif.slice_op1;
            sif.slice_cout   = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input logic [7:0] a, input logic [7:0] b, input logic c,
                           input logic [2:0] sel, input logic m);
        op1_in = a; op2_in = b; cin_in = c; opsel_in = sel; mode_in = m;
    endtask

    // Starts one operation; samples are taken after edges E0..E0+13.
    task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                          input logic c, input logic [2:0] sel, input logic m,
                          input logic [7:0] exp_res, input logic exp_cout,
                          output logic [7:0] op2_seq);
        int done_at;
        int done_cnt;
        int busy_cnt;
        op2_seq = 8'h00;
        done_at = -1; done_cnt = 0; busy_cnt = 0;
        set_ops(a, b, c, sel, m);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 14; i++) begin
            if (i < 8) op2_seq[i] = sif.slice_op2;
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = i;
            end
            tick();
        end
        n_cmp++;
        if (done_at !== 8) begin
            n_bad++;
            $display("FAIL %s done_latency: got %0d samples after start edge, expected 8", name, done_at);
        end
        n_cmp++;
        if (done_cnt !== 1) begin
            n_bad++;
            $display("FAIL %s done_count: got %0d, expected 1", name, done_cnt);
        end
        n_cmp++;
        if (busy_cnt !== 9) begin
            n_bad++;
            $display("FAIL %s busy_cycles: got %0d, expected 9", name, busy_cnt);
        end
        n_cmp++;
        if (result_out !== exp_res) begin
            n_bad++;
            $display("FAIL %s result_out: got %02h, expected %02h", name, result_out, exp_res);
        end
        n_cmp++;
        if (cout_out !== exp_cout) begin
            n_bad++;
            $display("FAIL %s cout_out: got %0b, expected %0b", name, cout_out, exp_cout);
        end
        $display("op %s: a=%02h b=%02h cin=%0b -> result=%02h cout=%0b", name, a, b, c, result_out, cout_out);
    endtask

    task automatic check_idle_zero(input string name);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL %s busy/done: got %0b/%0b, expected 0/0", name, busy, done);
        end
        n_cmp++;
        if (result_out !== 8'h00 || cout_out !== 1'b0) begin
            n_bad++;
            $display("FAIL %s result/cout: got %02h/%0b, expected 00/0", name, result_out, cout_out);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        check_idle_zero("reset");
        n_cmp++;
        if ({sif.slice_op1, sif.slice_op2, sif.slice_cin, sif.slice_opsel, sif.slice_mode} !== 7'b0) begin
            n_bad++;
            $display("FAIL reset slice_outputs: got %07b, expected 0000000",
                     {sif.slice_op1, sif.slice_op2, sif.slice_cin, sif.slice_opsel, sif.slice_mode});
        end
        rst_n = 1'b1;
        tick();
        $display("reset: busy=%0b done=%0b result=%02h", busy, done, result_out);
    endtask

    task automatic test_add();
        logic [7:0] seq;
        run_op("add_5A_33", 8'h5A, 8'h33, 1'b0, 3'b000, 1'b0, 8'h8D, 1'b0, seq);
        run_op("add_FF_01", 8'hFF, 8'h01, 1'b0, 3'b000, 1'b0, 8'h00, 1'b1, seq);
        run_op("add_00_00_cin", 8'h00, 8'h00, 1'b1, 3'b000, 1'b0, 8'h01, 1'b0, seq);
    endtask

    task automatic test_move();
        logic [7:0] seq;
        logic [7:0] exp_seq;
        exp_seq = 8'h5A;
        run_op("move_C3", 8'hC3, 8'h5A, 1'b0, 3'b010, 1'b0, 8'hC3, 1'b0, seq);
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (seq[k] !== exp_seq[k]) begin
                n_bad++;
                $display("FAIL move slice_op2_bit%0d: got %0b, expected %0b", k, seq[k], exp_seq[k]);
            end
        end
        n_cmp++;
        if (sif.slice_opsel !== 3'b010 || sif.slice_op1 !== 1'b0) begin
            n_bad++;
            $display("FAIL move idle_slice: got opsel=%03b op1=%0b, expected 010/0", sif.slice_opsel, sif.slice_op1);
        end
    endtask

    task automatic test_start_ignored();
        int done_cnt;
        done_cnt = 0;
        set_ops(8'h5A, 8'h33, 1'b0, 3'b000, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            start = 1'b0;
            if (i == 3) begin
                set_ops(8'hFF, 8'h01, 1'b1, 3'b000, 1'b0);
                start = 1'b1;
            end
            if (done) begin
                done_cnt++;
                start = 1'b1;
                n_cmp++;
                if (result_out !== 8'h8D || cout_out !== 1'b0) begin
                    n_bad++;
                    $display("FAIL ignore result: got %02h/%0b, expected 8D/0", result_out, cout_out);
                end
            end
            tick();
        end
        start = 1'b0;
        n_cmp++;
        if (done_cnt !== 1) begin
            n_bad++;
            $display("FAIL ignore done_count: got %0d, expected 1", done_cnt);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL ignore idle_busy: got %0b, expected 0", busy);
        end
        $display("start_ignored: result=%02h done_pulses=%0d", result_out, done_cnt);
    endtask

    task automatic test_reset_mid();
        int done_cnt;
        logic [7:0] seq;
        done_cnt = 0;
        set_ops(8'h12, 8'h34, 1'b0, 3'b000, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (done) done_cnt++;
            tick();
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_idle_zero("reset_mid");
        for (int i = 0; i < 14; i++) begin
            if (done) done_cnt++;
            tick();
        end
        n_cmp++;
        if (done_cnt !== 0) begin
            n_bad++;
            $display("FAIL reset_mid done_count: got %0d, expected 0", done_cnt);
        end
        $display("reset_mid: aborted, done_pulses=%0d", done_cnt);
        run_op("after_reset", 8'h0F, 8'h01, 1'b0, 3'b000, 1'b0, 8'h10, 1'b0, seq);
    endtask

    task automatic test_back_to_back();
        int done_idx [$];
        set_ops(8'h12, 8'h34, 1'b0, 3'b000, 1'b0);
        start = 1'b1;
        tick();
        for (int i = 0; i < 32; i++) begin
            if (i == 1) set_ops(8'h80, 8'h80, 1'b0, 3'b000, 1'b0);
            if (done) done_idx.push_back(i);
            if (i >= 9 && i < 18) begin
                n_cmp++;
                if (result_out !== 8'h46 || cout_out !== 1'b0) begin
                    n_bad++;
                    $display("FAIL b2b hold@%0d: got %02h/%0b, expected 46/0", i, result_out, cout_out);
                end
            end
            if (i == 9 || i == 19) begin
                n_cmp++;
                if (busy !== 1'b0) begin
                    n_bad++;
                    $display("FAIL b2b idle_gap@%0d: got busy=%0b, expected 0", i, busy);
                end
            end
            if (i == 10 || i == 20) begin
                n_cmp++;
                if (busy !== 1'b1) begin
                    n_bad++;
                    $display("FAIL b2b accept@%0d: got busy=%0b, expected 1", i, busy);
                end
            end
            if (i == 20) start = 1'b0;
            tick();
        end
        n_cmp++;
        if (done_idx.size() !== 3) begin
            n_bad++;
            $display("FAIL b2b done_count: got %0d, expected 3", done_idx.size());
        end else begin
            n_cmp++;
            if (done_idx[0] !== 8 || done_idx[1] !== 18 || done_idx[2] !== 28) begin
                n_bad++;
                $display("FAIL b2b done_times: got %0d,%0d,%0d expected 8,18,28",
                         done_idx[0], done_idx[1], done_idx[2]);
            end
        end
        n_cmp++;
        if (result_out !== 8'h00 || cout_out !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b final: got %02h/%0b, expected 00/1", result_out, cout_out);
        end
        $display("back_to_back: done_pulses=%0d final=%02h/%0b", done_idx.size(), result_out, cout_out);
    endtask

    initial begin
        test_reset();
        test_add();
        test_move();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
